mic1_datapath_regs: RTL and testbench

MIC1_DATAPATH_REGS -- requirements
Module: mic1_datapath_regs

---
 rtl/mic1_pkg.sv | 43 ++++
 rtl/mic1_rd_pipe.sv | 38 +++
 rtl/mic1_datapath_regs.sv | 141 ++++++++++++++
 tb/tb_mic1_datapath_regs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_pkg.sv
// Shared encodings for the MIC-1 register datapath: B-bus selects, C-enable bit
// positions (which double as register-array indices) and memory strobe payload.
package mic1_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned MBR_W_DEF   = 8;
    localparam int unsigned MEM_LAT_DEF = 1;

    localparam int unsigned C_EN_W   = 9;
    localparam int unsigned NUM_REGS = 10;

    // C-enable bit positions; MBR has no C-bus enable and sits after them
    localparam int unsigned CE_MAR  = 0;
    localparam int unsigned CE_MDR  = 1;
    localparam int unsigned CE_PC   = 2;
    localparam int unsigned CE_SP   = 3;
    localparam int unsigned CE_LV   = 4;
    localparam int unsigned CE_CPP  = 5;
    localparam int unsigned CE_TOS  = 6;
    localparam int unsigned CE_OPC  = 7;
    localparam int unsigned CE_H    = 8;
    localparam int unsigned REG_MBR = 9;

    typedef enum logic [3:0] {
        BSEL_MDR   = 4'd0,
        BSEL_PC    = 4'd1,
        BSEL_MBR_S = 4'd2,
        BSEL_MBR_U = 4'd3,
        BSEL_SP    = 4'd4,
        BSEL_LV    = 4'd5,
        BSEL_CPP   = 4'd6,
        BSEL_TOS   = 4'd7,
        BSEL_OPC   = 4'd8,
        BSEL_H     = 4'd9
    } b_sel_e;

    typedef struct packed {
        logic rd;
        logic wr;
        logic fetch;
    } mem_cmd_t;

endpackage

// File: rtl/mic1_rd_pipe.sv
// Valid-bit shifter tracking outstanding reads; ret fires on the edge where the
// oldest read's data is due, pend is high while any read is in flight.
module mic1_rd_pipe #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic ret,
    output logic pend
);

    logic [LAT-1:0] valid_q, valid_d;
    logic           pend_q, pend_d;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = issue;
        for (int unsigned i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
        end
        pend_d = |valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign ret  = valid_q[LAT-1];
    assign pend = pend_q;

endmodule

// File: rtl/mic1_datapath_regs.sv
// MIC-1 register file with A/B bus drive, registered memory strobes and
// latency-tracked RAM/ROM returns into MDR/MBR.
module mic1_datapath_regs
    import mic1_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       MBR_W    = MBR_W_DEF,
    parameter int unsigned       MEM_LAT  = MEM_LAT_DEF,
    parameter logic [DATA_W-1:0] SP_RESET = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] c_bus,
    input  logic [C_EN_W-1:0] c_en,
    input  logic [3:0]        b_sel,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              mem_fetch,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [MBR_W-1:0]  rom_rdata,
    output logic [DATA_W-1:0] a_bus,
    output logic [DATA_W-1:0] b_bus,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] rom_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              rom_rd,
    output logic              rd_pend,
    output logic              fetch_pend,
    output logic              coll_err,
    output logic [DATA_W-1:0] dbg_sp,
    output logic [DATA_W-1:0] dbg_lv,
    output logic [DATA_W-1:0] dbg_cpp,
    output logic [DATA_W-1:0] dbg_tos,
    output logic [DATA_W-1:0] dbg_opc,
    output logic [DATA_W-1:0] dbg_mbr
);

    localparam int unsigned PAD_W = DATA_W - MBR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    mem_cmd_t          strobe_q, strobe_d;
    logic              coll_q, coll_d;
    logic              ram_ret, rom_ret;

    logic [MBR_W-1:0]  mbr;
    logic [DATA_W-1:0] mbr_sext, mbr_zext;

    // A simultaneous rd+wr is resolved as a write only
    always_comb begin
        strobe_d.rd    = mem_rd & ~mem_wr;
        strobe_d.wr    = mem_wr;
        strobe_d.fetch = mem_fetch;
    end

    mic1_rd_pipe #(.LAT(MEM_LAT)) u_ram_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .issue (strobe_d.rd),
        .ret   (ram_ret),
        .pend  (rd_pend)
    );

    mic1_rd_pipe #(.LAT(MEM_LAT)) u_rom_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .issue (strobe_d.fetch),
        .ret   (rom_ret),
        .pend  (fetch_pend)
    );

    // C-bus writes take priority over a RAM return landing on the same edge
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < C_EN_W; i++) begin
            if (c_en[i]) begin
                regs_d[i] = c_bus;
            end
        end
        if (ram_ret && !c_en[CE_MDR]) begin
            regs_d[CE_MDR] = ram_rdata;
        end
        if (rom_ret) begin
            regs_d[REG_MBR] = DATA_W'(rom_rdata);
        end
        coll_d = coll_q | (ram_ret & c_en[CE_MDR]) | (mem_rd & mem_wr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == CE_SP) ? SP_RESET : '0;
            end
            strobe_q <= '0;
            coll_q   <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
            coll_q   <= coll_d;
        end
    end

    assign mbr      = regs_q[REG_MBR][MBR_W-1:0];
    assign mbr_sext = {{PAD_W{mbr[MBR_W-1]}}, mbr};
    assign mbr_zext = DATA_W'(mbr);

    always_comb begin
        b_bus = '0;
        case (b_sel)
            BSEL_MDR:   b_bus = regs_q[CE_MDR];
            BSEL_PC:    b_bus = regs_q[CE_PC];
            BSEL_MBR_S: b_bus = mbr_sext;
            BSEL_MBR_U: b_bus = mbr_zext;
            BSEL_SP:    b_bus = regs_q[CE_SP];
            BSEL_LV:    b_bus = regs_q[CE_LV];
            BSEL_CPP:   b_bus = regs_q[CE_CPP];
            BSEL_TOS:   b_bus = regs_q[CE_TOS];
            BSEL_OPC:   b_bus = regs_q[CE_OPC];
            BSEL_H:     b_bus = regs_q[CE_H];
            default:    b_bus = '0;
        endcase
    end

    assign a_bus     = regs_q[CE_H];
    assign ram_addr  = regs_q[CE_MAR];
    assign ram_wdata = regs_q[CE_MDR];
    assign rom_addr  = regs_q[CE_PC];
    assign ram_rd    = strobe_q.rd;
    assign ram_wr    = strobe_q.wr;
    assign rom_rd    = strobe_q.fetch;
    assign coll_err  = coll_q;
    assign dbg_sp    = regs_q[CE_SP];
    assign dbg_lv    = regs_q[CE_LV];
    assign dbg_cpp   = regs_q[CE_CPP];
    assign dbg_tos   = regs_q[CE_TOS];
    assign dbg_opc   = regs_q[CE_OPC];
    assign dbg_mbr   = regs_q[REG_MBR];

endmodule

// File: tb/tb_mic1_datapath_regs.sv
// Directed bench: strobe transactions are checked by a scoreboard monitor,
// register/bus state by inline checks, all against hand-computed values.
module tb_mic1_datapath_regs;
    import mic1_pkg::*;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] c_bus;
    logic [8:0]  c_en;
    logic [3:0]  b_sel;
    logic        mem_rd, mem_wr, mem_fetch;
    logic [31:0] ram_rdata;
    logic [7:0]  rom_rdata;
    logic [31:0] a_bus, b_bus, ram_addr, ram_wdata, rom_addr;
    logic        ram_rd, ram_wr, rom_rd, rd_pend, fetch_pend, coll_err;
    logic [31:0] dbg_sp, dbg_lv, dbg_cpp, dbg_tos, dbg_opc, dbg_mbr;

    mic1_datapath_regs #(.DATA_W(32), .MBR_W(8), .MEM_LAT(LAT), .SP_RESET(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst_n(rst_n), .c_bus(c_bus), .c_en(c_en), .b_sel(b_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_fetch(mem_fetch),
        .ram_rdata(ram_rdata), .rom_rdata(rom_rdata),
        .a_bus(a_bus), .b_bus(b_bus), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .rom_addr(rom_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .rom_rd(rom_rd),
        .rd_pend(rd_pend), .fetch_pend(fetch_pend), .coll_err(coll_err),
        .dbg_sp(dbg_sp), .dbg_lv(dbg_lv), .dbg_cpp(dbg_cpp), .dbg_tos(dbg_tos),
        .dbg_opc(dbg_opc), .dbg_mbr(dbg_mbr)
    );

    always #5 clk = ~clk;

    // kind = {rd, wr, fetch}
    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] bexp [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [31:0] a, input logic [31:0] w);
        exp_q.push_back(exp_t'{kind: k, addr: a, wdata: w});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_en = '0; mem_rd = 1'b0; mem_wr = 1'b0; mem_fetch = 1'b0;
    endtask

    // Scoreboard monitor: every strobe cycle must match the oldest expected transaction
    always @(negedge clk) begin
        if (ram_rd || ram_wr || rom_rd) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, ram_rd, ram_wr, rom_rd}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_kind", {29'd0, ram_rd, ram_wr, rom_rd}, {29'd0, mon_e.kind});
                if (mon_e.kind[2]) chk("rd_addr", ram_addr, mon_e.addr);
                if (mon_e.kind[1]) begin
                    chk("wr_addr", ram_addr, mon_e.addr);
                    chk("wr_data", ram_wdata, mon_e.wdata);
                end
                if (mon_e.kind[0]) chk("fetch_addr", rom_addr, mon_e.addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        c_bus = '0; b_sel = '0; ram_rdata = '0; rom_rdata = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_sp", dbg_sp, 32'hFFFF_FFFF);
        chk("rst_lv", dbg_lv, 32'h0);
        chk("rst_cpp", dbg_cpp, 32'h0);
        chk("rst_tos", dbg_tos, 32'h0);
        chk("rst_opc", dbg_opc, 32'h0);
        chk("rst_mbr", dbg_mbr, 32'h0);
        chk("rst_h", a_bus, 32'h0);
        chk("rst_mar", ram_addr, 32'h0);
        chk("rst_mdr", ram_wdata, 32'h0);
        chk("rst_pc", rom_addr, 32'h0);
        chk("rst_flags", {26'd0, ram_rd, ram_wr, rom_rd, rd_pend, fetch_pend, coll_err}, 32'h0);
        rst_n = 1'b1;
        step();

        // Load each C-bus register with a distinct value, then one hold cycle
        for (int unsigned i = 0; i < 9; i++) begin
            c_en = 9'(1) << i;
            c_bus = 32'h100 + 32'(i);
            step();
        end
        idle();
        c_bus = 32'hDEAD_0000;
        step();
        bexp = '{32'h101, 32'h102, 32'h0, 32'h0, 32'h103, 32'h104, 32'h105, 32'h106,
                 32'h107, 32'h108, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int j = 0; j < 16; j++) begin
            b_sel = 4'(j);
            #1;
            chk($sformatf("b_bus_sel%0d", j), b_bus, bexp[j]);
        end
        chk("a_bus_h", a_bus, 32'h108);
        chk("mar_hold", ram_addr, 32'h100);
        chk("sp_write", dbg_sp, 32'h103);

        // Single read, MAR written on the same edge
        c_en = 9'(1) << CE_MAR; c_bus = 32'h10; mem_rd = 1'b1;
        push(3'b100, 32'h10, 32'h0);
        step();
        idle();
        chk("rd_pend_issue", {31'd0, rd_pend}, 32'd1);
        ram_rdata = 32'hCAFE_BABE;
        step();
        chk("mdr_not_yet", ram_wdata, 32'h101);
        chk("rd_pend_mid", {31'd0, rd_pend}, 32'd1);
        step();
        chk("mdr_return", ram_wdata, 32'hCAFE_BABE);
        chk("rd_pend_done", {31'd0, rd_pend}, 32'd0);

        // Instruction fetches with negative and positive bytes
        c_en = 9'(1) << CE_PC; c_bus = 32'h20; mem_fetch = 1'b1;
        push(3'b001, 32'h20, 32'h0);
        step();
        idle();
        chk("fetch_pend_issue", {31'd0, fetch_pend}, 32'd1);
        rom_rdata = 8'h80;
        step();
        step();
        chk("fetch_pend_done", {31'd0, fetch_pend}, 32'd0);
        chk("mbr_80", dbg_mbr, 32'h80);
        b_sel = 4'd2; #1; chk("mbr_sext_80", b_bus, 32'hFFFF_FF80);
        b_sel = 4'd3; #1; chk("mbr_zext_80", b_bus, 32'h0000_0080);
        mem_fetch = 1'b1;
        push(3'b001, 32'h20, 32'h0);
        step();
        idle();
        rom_rdata = 8'h7F;
        step();
        step();
        b_sel = 4'd2; #1; chk("mbr_sext_7f", b_bus, 32'h0000_007F);

        // Read return colliding with a C-bus MDR write
        mem_rd = 1'b1;
        push(3'b100, 32'h10, 32'h0);
        step();
        idle();
        ram_rdata = 32'h5555_5555;
        step();
        c_en = 9'(1) << CE_MDR; c_bus = 32'h1234;
        step();
        idle();
        chk("coll_mdr", ram_wdata, 32'h1234);
        chk("coll_err_set", {31'd0, coll_err}, 32'd1);
        step();
        step();
        chk("coll_err_sticky", {31'd0, coll_err}, 32'd1);

        // Three back-to-back reads return in order on consecutive edges
        mem_rd = 1'b1;
        push(3'b100, 32'h10, 32'h0);
        push(3'b100, 32'h10, 32'h0);
        push(3'b100, 32'h10, 32'h0);
        step();
        step();
        chk("b2b_no_early", ram_wdata, 32'h1234);
        ram_rdata = 32'hAAAA_0001;
        step();
        mem_rd = 1'b0;
        chk("b2b_ret1", ram_wdata, 32'hAAAA_0001);
        ram_rdata = 32'hAAAA_0002;
        step();
        chk("b2b_ret2", ram_wdata, 32'hAAAA_0002);
        ram_rdata = 32'hAAAA_0003;
        step();
        chk("b2b_ret3", ram_wdata, 32'hAAAA_0003);
        chk("b2b_pend_done", {31'd0, rd_pend}, 32'd0);

        // Reset in the middle of a read
        mem_rd = 1'b1;
        push(3'b100, 32'h10, 32'h0);
        step();
        idle();
        ram_rdata = 32'h9999_9999;
        #6;
        rst_n = 1'b0;
        #1;
        chk("midrst_pend", {31'd0, rd_pend}, 32'd0);
        chk("midrst_strobe", {31'd0, ram_rd}, 32'd0);
        chk("midrst_coll", {31'd0, coll_err}, 32'd0);
        chk("midrst_sp", dbg_sp, 32'hFFFF_FFFF);
        chk("midrst_mdr", ram_wdata, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("postrst_mdr", ram_wdata, 32'h0);
        chk("postrst_pend", {31'd0, rd_pend}, 32'd0);

        // Write while a read is outstanding
        mem_rd = 1'b1;
        push(3'b100, 32'h0, 32'h0);
        step();
        idle();
        c_en = (9'(1) << CE_MAR) | (9'(1) << CE_MDR); c_bus = 32'h40; mem_wr = 1'b1;
        push(3'b010, 32'h40, 32'h40);
        step();
        idle();
        chk("wr_during_rd_pend", {31'd0, rd_pend}, 32'd1);
        chk("wr_during_rd_coll", {31'd0, coll_err}, 32'd0);
        step();
        chk("wr_during_rd_ret", ram_wdata, 32'h9999_9999);
        chk("wr_during_rd_coll2", {31'd0, coll_err}, 32'd0);

        // Simultaneous read and write: write only, flag raised
        mem_rd = 1'b1; mem_wr = 1'b1;
        push(3'b010, 32'h40, 32'h9999_9999);
        step();
        idle();
        chk("rdwr_coll", {31'd0, coll_err}, 32'd1);
        chk("rdwr_no_pend", {31'd0, rd_pend}, 32'd0);
        ram_rdata = 32'h7777_7777;
        step();
        step();
        step();
        chk("rdwr_no_load", ram_wdata, 32'h9999_9999);

        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
